// File: rtl/irq_scheduler.sv
// Three-line nested interrupt scheduler: edge-detects request lines, applies mask and
// in-service priority gating, and hands the highest eligible vector to the CPU.
module irq_scheduler #(
  parameter logic [11:0] VEC0 = 12'h100,
  parameter logic [11:0] VEC1 = 12'h200,
  parameter logic [11:0] VEC2 = 12'h300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  irq_in,
  input  logic        ie_set,
  input  logic        ie_clr,
  input  logic        mask_we,
  input  logic [2:0]  mask_wdata,
  input  logic        int_ack,
  input  logic        eret,
  output logic        int_req,
  output logic [11:0] int_vec,
  output logic [2:0]  pending,
  output logic [2:0]  in_service,
  output logic        ie
);

  typedef enum logic {IDLE, REQ} state_e;

  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic        int_req_q, int_req_d;
  logic [11:0] int_vec_q, int_vec_d;
  logic [2:0]  pending_q, pending_d;
  logic [2:0]  in_service_q, in_service_d;
  logic [2:0]  mask_q, mask_d;
  logic        ie_q, ie_d;
  logic [2:0]  irq_d_q;

  logic [2:0]  rise;
  logic [2:0]  above;
  logic [2:0]  eligible;
  logic [1:0]  top_sel;
  logic [2:0]  is_top;
  logic [2:0]  sel_oh;
  logic        ack;

  function automatic logic [11:0] vec_of(input logic [1:0] s);
    case (s)
      2'd2:    return VEC2;
      2'd1:    return VEC1;
      default: return VEC0;
    endcase
  endfunction

  assign rise   = irq_in & ~irq_d_q;
  assign sel_oh = 3'b001 << sel_q;
  assign ack    = (state_q == REQ) && int_ack;

  // Only lines strictly above the highest in-service line may interrupt.
  always_comb begin
    above  = 3'b111;
    is_top = 3'b000;
    if (in_service_q[2]) begin
      above  = 3'b000;
      is_top = 3'b100;
    end else if (in_service_q[1]) begin
      above  = 3'b100;
      is_top = 3'b010;
    end else if (in_service_q[0]) begin
      above  = 3'b110;
      is_top = 3'b001;
    end
  end

  assign eligible = pending_q & ~mask_q & above;

  always_comb begin
    top_sel = 2'd0;
    if (eligible[2])      top_sel = 2'd2;
    else if (eligible[1]) top_sel = 2'd1;
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    int_req_d = int_req_q;
    int_vec_d = int_vec_q;
    case (state_q)
      IDLE: begin
        if (ie_q && (|eligible)) begin
          state_d   = REQ;
          sel_d     = top_sel;
          int_req_d = 1'b1;
          int_vec_d = vec_of(top_sel);
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d   = IDLE;
          int_req_d = 1'b0;
        end else if (ie_q && (|eligible)) begin
          sel_d     = top_sel;
          int_vec_d = vec_of(top_sel);
        end else begin
          state_d   = IDLE;
          int_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        int_req_d = 1'b0;
      end
    endcase

    // A new rising edge outranks the acknowledge clearing the same pending bit.
    pending_d    = (pending_q & ~(ack ? sel_oh : 3'b000)) | rise;
    in_service_d = (in_service_q & ~(eret ? is_top : 3'b000)) | (ack ? sel_oh : 3'b000);
    mask_d       = mask_we ? mask_wdata : mask_q;

    ie_d = ie_q;
    if (ie_set) ie_d = 1'b1;
    if (ie_clr) ie_d = 1'b0;
    if (eret)   ie_d = 1'b1;
    if (ack)    ie_d = 1'b0;
  end

  // Reset primes the edge detector high so lines already asserted do not fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 2'd0;
      int_req_q    <= 1'b0;
      int_vec_q    <= 12'h000;
      pending_q    <= 3'b000;
      in_service_q <= 3'b000;
      mask_q       <= 3'b000;
      ie_q         <= 1'b0;
      irq_d_q      <= 3'b111;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      int_req_q    <= int_req_d;
      int_vec_q    <= int_vec_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      mask_q       <= mask_d;
      ie_q         <= ie_d;
      irq_d_q      <= irq_in;
    end
  end

  assign int_req    = int_req_q;
  assign int_vec    = int_vec_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign ie         = ie_q;

endmodule

// File: tb/tb_irq_scheduler.sv
// Directed bench for irq_scheduler: linear scenario walk with immediate-assertion checks
// against hand-computed values after each clock edge.
module tb_irq_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  irq_in;
  logic        ie_set;
  logic        ie_clr;
  logic        mask_we;
  logic [2:0]  mask_wdata;
  logic        int_ack;
  logic        eret;
  logic        int_req;
  logic [11:0] int_vec;
  logic [2:0]  pending;
  logic [2:0]  in_service;
  logic        ie;

  int checks   = 0;
  int failures = 0;

  irq_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .ie_set     (ie_set),
    .ie_clr     (ie_clr),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_ack    (int_ack),
    .eret       (eret),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .pending    (pending),
    .in_service (in_service),
    .ie         (ie)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; irq_in = 3'b111; ie_set = 1'b0; ie_clr = 1'b0;
    mask_we = 1'b0; mask_wdata = 3'b000; int_ack = 1'b0; eret = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_int_req", {11'd0, int_req}, 12'd0);
    checkOutput("rst_int_vec", int_vec, 12'h000);
    checkOutput("rst_pending", {9'd0, pending}, 12'd0);
    checkOutput("rst_in_service", {9'd0, in_service}, 12'd0);
    checkOutput("rst_ie", {11'd0, ie}, 12'd0);
    rst = 1'b0;
    applyStimulus();
    checkOutput("held_high_no_pending", {9'd0, pending}, 12'd0);
    irq_in = 3'b000;
    applyStimulus();

    // Single request on line 1
    ie_set = 1'b1;
    applyStimulus();
    ie_set = 1'b0;
    checkOutput("ie_set", {11'd0, ie}, 12'd1);
    irq_in = 3'b010;
    applyStimulus();
    irq_in = 3'b000;
    checkOutput("l1_pending", {9'd0, pending}, 12'h002);
    checkOutput("l1_no_req_yet", {11'd0, int_req}, 12'd0);
    applyStimulus();
    checkOutput("l1_int_req", {11'd0, int_req}, 12'd1);
    checkOutput("l1_int_vec", int_vec, 12'h200);
    int_ack = 1'b1;
    applyStimulus();
    int_ack = 1'b0;
    checkOutput("l1_ack_in_service", {9'd0, in_service}, 12'h002);
    checkOutput("l1_ack_ie", {11'd0, ie}, 12'd0);
    checkOutput("l1_ack_pending", {9'd0, pending}, 12'd0);
    checkOutput("l1_ack_req_low", {11'd0, int_req}, 12'd0);
    checkOutput("l1_vec_hold", int_vec, 12'h200);
    eret = 1'b1;
    applyStimulus();
    eret = 1'b0;
    checkOutput("l1_eret_in_service", {9'd0, in_service}, 12'd0);
    checkOutput("l1_eret_ie", {11'd0, ie}, 12'd1);

    // Simultaneous lines 2 and 0: line 2 first, then line 0 after return
    irq_in = 3'b101;
    applyStimulus();
    irq_in = 3'b000;
    checkOutput("dual_pending", {9'd0, pending}, 12'h005);
    applyStimulus();
    checkOutput("dual_vec_first", int_vec, 12'h300);
    int_ack = 1'b1;
    applyStimulus();
    int_ack = 1'b0;
    checkOutput("dual_ack_in_service", {9'd0, in_service}, 12'h004);
    checkOutput("dual_ack_pending", {9'd0, pending}, 12'h001);
    eret = 1'b1;
    applyStimulus();
    eret = 1'b0;
    checkOutput("dual_eret_in_service", {9'd0, in_service}, 12'd0);
    checkOutput("dual_eret_ie", {11'd0, ie}, 12'd1);
    checkOutput("dual_eret_req_low", {11'd0, int_req}, 12'd0);
    applyStimulus();
    checkOutput("dual_second_req", {11'd0, int_req}, 12'd1);
    checkOutput("dual_second_vec", int_vec, 12'h100);

    // Nesting: serve line 0, then line 2 preempts, line 0 repeat stays pending
    int_ack = 1'b1;
    applyStimulus();
    int_ack = 1'b0;
    checkOutput("nest_l0_in_service", {9'd0, in_service}, 12'h001);
    ie_set = 1'b1;
    applyStimulus();
    ie_set = 1'b0;
    irq_in = 3'b100;
    applyStimulus();
    irq_in = 3'b000;
    applyStimulus();
    checkOutput("nest_l2_req", {11'd0, int_req}, 12'd1);
    checkOutput("nest_l2_vec", int_vec, 12'h300);
    int_ack = 1'b1;
    applyStimulus();
    int_ack = 1'b0;
    checkOutput("nest_both_in_service", {9'd0, in_service}, 12'h005);
    ie_set = 1'b1;
    applyStimulus();
    ie_set = 1'b0;
    irq_in = 3'b001;
    applyStimulus();
    irq_in = 3'b000;
    applyStimulus();
    checkOutput("nest_l0_repeat_pending", {9'd0, pending}, 12'h001);
    checkOutput("nest_l0_repeat_no_req", {11'd0, int_req}, 12'd0);
    eret = 1'b1;
    applyStimulus();
    checkOutput("nest_eret_top_only", {9'd0, in_service}, 12'h001);
    applyStimulus();
    eret = 1'b0;
    checkOutput("nest_eret_all", {9'd0, in_service}, 12'd0);
    checkOutput("nest_blocked_meanwhile", {11'd0, int_req}, 12'd0);
    applyStimulus();
    checkOutput("nest_l0_finally", int_vec, 12'h100);

    // Preemption while requesting, then reset in REQ
    irq_in = 3'b100;
    applyStimulus();
    irq_in = 3'b000;
    checkOutput("preempt_vec_old", int_vec, 12'h100);
    applyStimulus();
    checkOutput("preempt_vec_new", int_vec, 12'h300);
    checkOutput("preempt_req_held", {11'd0, int_req}, 12'd1);
    rst = 1'b1; int_ack = 1'b1; ie_set = 1'b1;
    applyStimulus();
    rst = 1'b0; int_ack = 1'b0; ie_set = 1'b0;
    checkOutput("midreq_rst_req", {11'd0, int_req}, 12'd0);
    checkOutput("midreq_rst_vec", int_vec, 12'h000);
    checkOutput("midreq_rst_pending", {9'd0, pending}, 12'd0);
    checkOutput("midreq_rst_in_service", {9'd0, in_service}, 12'd0);
    checkOutput("midreq_rst_ie", {11'd0, ie}, 12'd0);
    applyStimulus();

    // Masking holds the request back without dropping it
    ie_set = 1'b1; mask_we = 1'b1; mask_wdata = 3'b100;
    applyStimulus();
    ie_set = 1'b0; mask_we = 1'b0;
    irq_in = 3'b100;
    applyStimulus();
    irq_in = 3'b000;
    applyStimulus();
    checkOutput("mask_pending", {9'd0, pending}, 12'h004);
    checkOutput("mask_no_req", {11'd0, int_req}, 12'd0);
    mask_we = 1'b1; mask_wdata = 3'b000;
    applyStimulus();
    mask_we = 1'b0;
    applyStimulus();
    checkOutput("unmask_req", {11'd0, int_req}, 12'd1);
    checkOutput("unmask_vec", int_vec, 12'h300);

    // Enable withdrawn during REQ, then set/clear contention
    ie_clr = 1'b1;
    applyStimulus();
    ie_clr = 1'b0;
    checkOutput("ieclr_ie", {11'd0, ie}, 12'd0);
    applyStimulus();
    checkOutput("ieclr_req_drop", {11'd0, int_req}, 12'd0);
    checkOutput("ieclr_pending_kept", {9'd0, pending}, 12'h004);
    ie_set = 1'b1; ie_clr = 1'b1;
    applyStimulus();
    ie_clr = 1'b0;
    checkOutput("set_clr_clear_wins", {11'd0, ie}, 12'd0);
    applyStimulus();
    ie_set = 1'b0;
    applyStimulus();
    checkOutput("rerequest", {11'd0, int_req}, 12'd1);

    // New rising edge coinciding with acknowledge of the same line
    int_ack = 1'b1; irq_in = 3'b100;
    applyStimulus();
    int_ack = 1'b0; irq_in = 3'b000;
    checkOutput("ack_rise_pending_kept", {9'd0, pending}, 12'h004);
    checkOutput("ack_rise_in_service", {9'd0, in_service}, 12'h004);
    checkOutput("ack_rise_ie", {11'd0, ie}, 12'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
